// File: rtl/shiftrows_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shiftrows_pkg
//  Purpose  : Shared constants and row-offset helpers for the ShiftRows path.
//  Revision : 1.0 - initial release
// ============================================================================
package shiftrows_pkg;

   localparam int c_rows   = 4;
   localparam int c_byte_w = 8;

   // The only state widths Rijndael defines for this datapath.
   localparam int c_nb_128 = 4;
   localparam int c_nb_192 = 6;
   localparam int c_nb_256 = 8;

   function automatic bit nb_is_legal(input int nb);
      return (nb == c_nb_128) || (nb == c_nb_192) || (nb == c_nb_256);
   endfunction

   // Number of bits held by one row of the state.
   function automatic int row_bits(input int nb);
      return c_byte_w * nb;
   endfunction

   // Rotation amount C_r for row r.
   function automatic int row_offset(input int nb, input int r);
      int off;
      case (r)
         1:       off = 1;
         2:       off = (nb == c_nb_256) ? 3 : 2;
         3:       off = (nb == c_nb_256) ? 4 : 3;
         default: off = 0;
      endcase
      return off;
   endfunction

endpackage
`default_nettype wire

// File: rtl/shiftrows_core.sv
`default_nettype none
// ============================================================================
//  Module   : shiftrows_core
//  Purpose  : Combinational ShiftRows / InvShiftRows byte permutation.
//  Revision : 1.0 - initial release
// ============================================================================
module shiftrows_core
   import shiftrows_pkg::*;
#(
   parameter int NB = 4
) (
   input  logic [c_rows*c_byte_w*NB-1:0] state,
   input  logic                          inv,
   output logic [c_rows*c_byte_w*NB-1:0] shifted
);

   localparam int c_w     = c_rows * row_bits(NB);
   localparam int c_row_w = row_bits(NB);

   for (genvar r = 0; r < c_rows; r++) begin : g_row
      for (genvar c = 0; c < NB; c++) begin : g_col
         // Forward rotates the row left, inverse rotates it right.
         localparam int c_src_fwd = (c + row_offset(NB, r)) % NB;
         localparam int c_src_inv = (c + NB - row_offset(NB, r)) % NB;
         localparam int c_dst_msb = c_w - 1 - r * c_row_w - c * c_byte_w;
         localparam int c_fwd_msb = c_w - 1 - r * c_row_w - c_src_fwd * c_byte_w;
         localparam int c_inv_msb = c_w - 1 - r * c_row_w - c_src_inv * c_byte_w;

         assign shifted[c_dst_msb -: c_byte_w] = inv ? state[c_inv_msb -: c_byte_w]
                                                     : state[c_fwd_msb -: c_byte_w];
      end
   end

endmodule
`default_nettype wire

// File: rtl/shiftrows_stream.sv
`default_nettype none
// ============================================================================
//  Module   : shiftrows_stream
//  Purpose  : Registered ShiftRows / InvShiftRows stage with a 2-entry
//             valid/ready output buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module shiftrows_stream
   import shiftrows_pkg::*;
#(
   parameter int NB    = 4,
   parameter int DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_inv,
   input  logic [c_rows*c_byte_w*NB-1:0] in_data,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [c_rows*c_byte_w*NB-1:0] out_data,
   output logic                          out_inv,
   output logic [1:0]                    occupancy
);

   localparam int c_w = c_rows * row_bits(NB);

   if (!nb_is_legal(NB)) begin : g_bad_nb
      $error("shiftrows_stream: NB must be 4, 6 or 8");
   end

   if (DEPTH != 2) begin : g_bad_depth
      $error("shiftrows_stream: DEPTH must be 2");
   end

   logic [c_w-1:0] w_shifted;
   logic           w_push;
   logic           w_pop;

   logic [c_w-1:0] r_mem [2];
   logic [1:0]     r_mem_inv;
   logic           r_wr_ptr;
   logic           r_rd_ptr;
   logic [1:0]     r_count;

   shiftrows_core #(
      .NB (NB)
   ) u_core (
      .state   (in_data),
      .inv     (in_inv),
      .shifted (w_shifted)
   );

   // in_ready depends only on the count register, never on out_ready.
   assign in_ready  = (r_count != 2'd2);
   assign out_valid = (r_count != 2'd0);
   assign occupancy = r_count;
   assign out_data  = out_valid ? r_mem[r_rd_ptr]     : '0;
   assign out_inv   = out_valid ? r_mem_inv[r_rd_ptr] : 1'b0;

   assign w_push = in_valid && in_ready;
   assign w_pop  = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem[0]  <= '0;
         r_mem[1]  <= '0;
         r_mem_inv <= '0;
         r_wr_ptr  <= 1'b0;
         r_rd_ptr  <= 1'b0;
         r_count   <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr]     <= w_shifted;
            r_mem_inv[r_wr_ptr] <= in_inv;
            r_wr_ptr            <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire
